register_file_write_arbiter: RTL

- Shares the single write port (D, DA, w) of the 32 x 64 register file between two writeback requesters: requester 0 is ALU writeback, requester 1 is memory-load writeback.
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin arbiter drains the slots one write per cycle.
- Writes to the zero register are discarded, and stall cycles are counted for performance debug.

---
 rtl/register_file_write_arbiter_pkg.sv | 26 ++
 rtl/register_file_write_arbiter_if.sv | 40 ++++
 rtl/register_file_write_arbiter_wb_hold_slot.sv | 33 +++
 rtl/register_file_write_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/register_file_write_arbiter_pkg.sv
// Shared types for the writeback arbiter: register address width, zero-register
// index, the holding-slot record and the one-hot grant encoding.
package register_file_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam logic [REG_ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } slot_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_0    = 2'b01,
    GNT_1    = 2'b10
  } grant_e;

  // A held entry competes for the port only when it targets a real register.
  function automatic logic is_load(input slot_t s, input logic [REG_ADDR_W-1:0] zero_reg);
    return s.valid && (s.addr != zero_reg);
  endfunction

endpackage

// File: rtl/register_file_write_arbiter_if.sv
// Bundles both writeback request handshakes plus the register file write port
// and debug outputs; master = requesters/consumer side, slave = arbiter side.
interface register_file_write_arbiter_if
  import register_file_write_arbiter_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 16
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [REG_ADDR_W-1:0] req0_addr;
  logic [N-1:0]          req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [REG_ADDR_W-1:0] req1_addr;
  logic [N-1:0]          req1_data;

  logic [N-1:0]          D;
  logic [REG_ADDR_W-1:0] DA;
  logic                  w;
  logic [1:0]            grant;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  D, DA, w, grant, stall_count
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output D, DA, w, grant, stall_count
  );

endinterface

// File: rtl/register_file_write_arbiter_wb_hold_slot.sv
// One-entry writeback holding register; loads on valid&&ready, clears on drain.
// Ready is high when empty or draining this cycle, so a drained slot refills back-to-back.
module wb_hold_slot
  import register_file_write_arbiter_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [REG_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_data,
  input  logic                  drain,
  output logic                  ready,
  output slot_t                 slot
);

  slot_t slot_q;

  assign ready = !slot_q.valid || drain;
  assign slot  = slot_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_q <= '0;
    end else if (req_valid && ready) begin
      slot_q.valid <= 1'b1;
      slot_q.addr  <= req_addr;
      slot_q.data  <= req_data;
    end else if (drain) begin
      slot_q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/register_file_write_arbiter.sv
// Round-robin sharing of the register file write port between ALU and load writeback.
// Write issues 1 cycle after acceptance (2 if arbitration lost); port driven from slot registers only.
module register_file_write_arbiter
  import register_file_write_arbiter_pkg::*;
#(
  parameter int                    N        = DATA_W,
  parameter logic [REG_ADDR_W-1:0] ZERO_REG = XZR_ADDR,
  parameter int                    CNT_W    = 16
)
(
  input  logic                          clock,
  input  logic                          reset,
  register_file_write_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  slot_t                 slot0;
  slot_t                 slot1;
  logic                  load0;
  logic                  load1;
  logic                  drop0;
  logic                  drop1;
  logic                  drain0;
  logic                  drain1;
  logic                  ptr;
  logic                  ptr_nxt;
  grant_e                grant;
  logic                  stalled;
  logic [CNT_W-1:0]      stall_q;
  logic [N-1:0]          wr_data;
  logic [REG_ADDR_W-1:0] wr_addr;

  wb_hold_slot u_slot0 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (bus.req0_valid),
    .req_addr  (bus.req0_addr),
    .req_data  (bus.req0_data),
    .drain     (drain0),
    .ready     (bus.req0_ready),
    .slot      (slot0)
  );

  wb_hold_slot u_slot1 (
    .clock     (clock),
    .reset     (reset),
    .req_valid (bus.req1_valid),
    .req_addr  (bus.req1_addr),
    .req_data  (bus.req1_data),
    .drain     (drain1),
    .ready     (bus.req1_ready),
    .slot      (slot1)
  );

  assign load0 = is_load(slot0, ZERO_REG);
  assign load1 = is_load(slot1, ZERO_REG);
  assign drop0 = slot0.valid && !load0;
  assign drop1 = slot1.valid && !load1;

  // Zero-register entries vanish on their first valid cycle without touching the port.
  assign drain0 = (grant == GNT_0) || drop0;
  assign drain1 = (grant == GNT_1) || drop1;

  always_comb begin
    grant   = GNT_NONE;
    ptr_nxt = ptr;
    case ({load1, load0})
      2'b11: begin
        grant   = ptr ? GNT_1 : GNT_0;
        ptr_nxt = ~ptr;
      end
      2'b01: begin
        grant   = GNT_0;
        ptr_nxt = 1'b1;
      end
      2'b10: begin
        grant   = GNT_1;
        ptr_nxt = 1'b0;
      end
      default: begin
        grant   = GNT_NONE;
        ptr_nxt = ptr;
      end
    endcase
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    case (grant)
      GNT_0: begin
        wr_addr = slot0.addr;
        wr_data = slot0.data;
      end
      GNT_1: begin
        wr_addr = slot1.addr;
        wr_data = slot1.data;
      end
      default: begin
        wr_addr = '0;
        wr_data = '0;
      end
    endcase
  end

  // At most one loadable slot can be waiting, so this is a single-step increment.
  assign stalled = (load0 && (grant != GNT_0)) || (load1 && (grant != GNT_1));

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr     <= 1'b0;
      stall_q <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (stalled && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.D           = wr_data;
  assign bus.DA          = wr_addr;
  assign bus.w           = (grant != GNT_NONE);
  assign bus.grant       = grant;
  assign bus.stall_count = stall_q;

endmodule
